// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared types for the pipeline sequencing controller
// Contents: REG_ADDR_W, pipe_state_t (BOOT/RUN/HALT/STEP), ctrl_out_t (five fetch/decode controls)
package riscv_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_flush;
        logic pc_src;
        logic id_ex_bubble;
    } ctrl_out_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - combinational load-use and ID-branch operand hazard detection
// Inputs : id_rs1_i/id_rs2_i + use flags, id_is_branch_i, ex_rd_i/ex_reg_write_i/ex_mem_read_i, mem_rd_i/mem_mem_read_i
// Outputs: lu_o (load-use), bh_o (branch operand hazard), hz_o (either)
module pipe_hazard_detect
    import riscv_pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic                  id_is_branch_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_reg_write_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_mem_read_i,
    output logic                  lu_o,
    output logic                  bh_o,
    output logic                  hz_o
);

    logic ex_match;
    logic mem_match;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    assign ex_match  = (ex_rd_i != '0) &&
                       ((id_use_rs1_i && (ex_rd_i == id_rs1_i)) ||
                        (id_use_rs2_i && (ex_rd_i == id_rs2_i)));
    assign mem_match = (mem_rd_i != '0) &&
                       ((id_use_rs1_i && (mem_rd_i == id_rs1_i)) ||
                        (id_use_rs2_i && (mem_rd_i == id_rs2_i)));

    assign lu_o = ex_mem_read_i && ex_match;
    // Branches compare in ID, so an ALU result still in EX or load data still in MEM is not yet forwardable.
    assign bh_o = id_is_branch_i && ((ex_reg_write_i && ex_match) || (mem_mem_read_i && mem_match));
    assign hz_o = lu_o || bh_o;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline sequencing controller: stalls, redirects, boot/halt/step FSM, perf counters
// Build option: PIPE_CTRL_DEBUG_EN enables HALT/STEP and the stall/flush counters.
// Inputs : clk, reset_n (async, active-low), ID operands/branch info, EX/MEM producer info, imem_ready, dbg_halt_req, dbg_step
// Outputs: pc_write, IF_ID_write, IF_flush, pc_src, ID_EX_bubble, halted, stall_cnt, flush_cnt
module pipeline_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_is_branch,
    input  logic                  branch_taken,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_mem_read,
    input  logic                  imem_ready,
    input  logic                  dbg_halt_req,
    input  logic                  dbg_step,
    output logic                  pc_write,
    output logic                  IF_ID_write,
    output logic                  IF_flush,
    output logic                  pc_src,
    output logic                  ID_EX_bubble,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    pipe_state_t state_q;
    pipe_state_t state_d;
    ctrl_out_t   run_ctrl;
    ctrl_out_t   ctrl;
    logic        lu;
    logic        bh;
    logic        hz;
    logic        redirect;
    logic        quiet;

    pipe_hazard_detect u_hazard (
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_use_rs1_i   (id_use_rs1),
        .id_use_rs2_i   (id_use_rs2),
        .id_is_branch_i (id_is_branch),
        .ex_rd_i        (ex_rd),
        .ex_reg_write_i (ex_reg_write),
        .ex_mem_read_i  (ex_mem_read),
        .mem_rd_i       (mem_rd),
        .mem_mem_read_i (mem_mem_read),
        .lu_o           (lu),
        .bh_o           (bh),
        .hz_o           (hz)
    );

    // branch_taken is only trustworthy once operands are hazard-free, hence the priority order.
    assign redirect = id_is_branch && branch_taken;
    assign quiet    = !hz && !redirect && imem_ready;

    always_comb begin
        run_ctrl = '0;
        if (hz) begin
            run_ctrl.id_ex_bubble = 1'b1;
        end else if (redirect) begin
            run_ctrl.pc_src      = 1'b1;
            run_ctrl.pc_write    = 1'b1;
            run_ctrl.if_flush    = 1'b1;
            run_ctrl.if_id_write = 1'b1;
        end else if (!imem_ready) begin
            // PC holds while IF/ID takes a flushed bubble so ID does not re-execute stale data.
            run_ctrl.if_flush    = 1'b1;
            run_ctrl.if_id_write = 1'b1;
        end else begin
            run_ctrl.pc_write    = 1'b1;
            run_ctrl.if_id_write = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
`ifdef PIPE_CTRL_DEBUG_EN
            // Halt is only accepted on a clean advancing cycle so a redirect or stall is never split.
            RUN:  if (dbg_halt_req && quiet) state_d = HALT;
            HALT: begin
                if (!dbg_halt_req) begin
                    state_d = RUN;
                end else if (dbg_step) begin
                    state_d = STEP;
                end
            end
            STEP: if (run_ctrl.pc_write) state_d = HALT;
`else
            RUN:  state_d = RUN;
`endif
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            BOOT: begin
                ctrl.if_flush     = 1'b1;
                ctrl.id_ex_bubble = 1'b1;
            end
            RUN, STEP: ctrl = run_ctrl;
            default:   ctrl.id_ex_bubble = 1'b1;
        endcase
    end

    assign pc_write     = ctrl.pc_write;
    assign IF_ID_write  = ctrl.if_id_write;
    assign IF_flush     = ctrl.if_flush;
    assign pc_src       = ctrl.pc_src;
    assign ID_EX_bubble = ctrl.id_ex_bubble;

`ifdef PIPE_CTRL_DEBUG_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic             cnt_active;

    assign cnt_active = (state_q == RUN) || (state_q == STEP);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_active && !ctrl.pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (cnt_active && ctrl.if_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = (state_q == HALT);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_dbg;
    assign unused_dbg = dbg_halt_req ^ dbg_step ^ lu ^ bh;
    assign halted     = 1'b0;
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl with a behavioural reference model
module tb_pipeline_ctrl;

    localparam int CNT_W = 16;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_CTRL_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_STEP = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use_rs1, id_use_rs2, id_is_branch, branch_taken;
    logic       ex_reg_write, ex_mem_read, mem_mem_read, imem_ready;
    logic       dbg_halt_req, dbg_step;
    logic       pc_write, IF_ID_write, IF_flush, pc_src, ID_EX_bubble, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    int          m_mode = M_BOOT;
    int          m_next_mode = M_BOOT;
    int unsigned m_stall = 0, m_flush = 0, m_next_stall = 0, m_next_flush = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_is_branch (id_is_branch),
        .branch_taken (branch_taken),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .mem_rd       (mem_rd),
        .mem_mem_read (mem_mem_read),
        .imem_ready   (imem_ready),
        .dbg_halt_req (dbg_halt_req),
        .dbg_step     (dbg_step),
        .pc_write     (pc_write),
        .IF_ID_write  (IF_ID_write),
        .IF_flush     (IF_flush),
        .pc_src       (pc_src),
        .ID_EX_bubble (ID_EX_bubble),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit dep(input logic [4:0] rd, input logic [4:0] rs, input logic rd_used);
        return rd_used && (rd != 5'd0) && (rd == rs);
    endfunction

    // Reference model: state advances on the clock, resets asynchronously.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode  = M_BOOT;
            m_stall = 0;
            m_flush = 0;
        end else begin
            m_mode  = m_next_mode;
            m_stall = m_next_stall;
            m_flush = m_next_flush;
        end
    end

    // Compare process: expected outputs from the rules, checked every cycle away from the edge.
    always @(negedge clk) begin : compare
        bit hz, taken, active;
        bit e_pw, e_ifid, e_fl, e_src, e_bub;
        hz = (ex_mem_read && (dep(ex_rd, id_rs1, id_use_rs1) || dep(ex_rd, id_rs2, id_use_rs2))) ||
             (id_is_branch &&
              ((ex_reg_write && (dep(ex_rd, id_rs1, id_use_rs1) || dep(ex_rd, id_rs2, id_use_rs2))) ||
               (mem_mem_read && (dep(mem_rd, id_rs1, id_use_rs1) || dep(mem_rd, id_rs2, id_use_rs2)))));
        taken  = id_is_branch && branch_taken;
        active = (m_mode == M_RUN) || (m_mode == M_STEP);
        {e_pw, e_ifid, e_fl, e_src, e_bub} = 5'b0;
        if (m_mode == M_BOOT) begin
            e_fl = 1; e_bub = 1;
        end else if (m_mode == M_HALT) begin
            e_bub = 1;
        end else if (hz) begin
            e_bub = 1;
        end else if (taken) begin
            e_src = 1; e_pw = 1; e_fl = 1; e_ifid = 1;
        end else if (!imem_ready) begin
            e_fl = 1; e_ifid = 1;
        end else begin
            e_pw = 1; e_ifid = 1;
        end
        check("m_pc_write", pc_write, e_pw);
        check("m_IF_ID_write", IF_ID_write, e_ifid);
        check("m_IF_flush", IF_flush, e_fl);
        check("m_pc_src", pc_src, e_src);
        check("m_ID_EX_bubble", ID_EX_bubble, e_bub);
        check("m_halted", halted, DBG && (m_mode == M_HALT));
        check("m_stall_cnt", stall_cnt, DBG ? m_stall : 0);
        check("m_flush_cnt", flush_cnt, DBG ? m_flush : 0);

        m_next_mode = m_mode;
        case (m_mode)
            M_BOOT: m_next_mode = M_RUN;
            M_RUN:  if (DBG && dbg_halt_req && !hz && !taken && imem_ready) m_next_mode = M_HALT;
            M_HALT: m_next_mode = !dbg_halt_req ? M_RUN : (dbg_step ? M_STEP : M_HALT);
            default: m_next_mode = e_pw ? M_HALT : M_STEP;
        endcase
        m_next_stall = (active && !e_pw && m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
        m_next_flush = (active && e_fl && m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
    end

    task automatic clear_inputs;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_is_branch = 0; branch_taken = 0;
        ex_reg_write = 0; ex_mem_read = 0; mem_mem_read = 0; imem_ready = 1;
        dbg_halt_req = 0; dbg_step = 0;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic advance;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        settle();
        check("reset_IF_flush", IF_flush, 1);
        check("reset_pc_write", pc_write, 0);
        check("reset_halted", halted, 0);
        advance();
        reset_n = 1'b1;
        settle();
        check("boot_IF_flush", IF_flush, 1);
        check("boot_pc_write", pc_write, 0);
        advance();
        settle();
        check("run_pc_write", pc_write, 1);
        check("run_stall_cnt", stall_cnt, 0);

        // Load-use on rs2
        advance();
        ex_mem_read = 1; ex_rd = 14; id_rs2 = 14; id_use_rs2 = 1;
        settle();
        check("lu_pc_write", pc_write, 0);
        check("lu_IF_ID_write", IF_ID_write, 0);
        check("lu_bubble", ID_EX_bubble, 1);
        advance();
        clear_inputs();
        settle();
        check("lu_resume", pc_write, 1);
`ifdef PIPE_CTRL_DEBUG_EN
        check("lu_stall_cnt", stall_cnt, 1);
`endif

        // Branch hazard on an ALU producer, then the taken redirect
        advance();
        id_is_branch = 1; branch_taken = 1; ex_reg_write = 1; ex_rd = 14; id_rs1 = 14; id_use_rs1 = 1;
        settle();
        check("bh_pc_write", pc_write, 0);
        check("bh_pc_src", pc_src, 0);
        advance();
        ex_reg_write = 0; ex_rd = 0;
        settle();
        check("br_pc_src", pc_src, 1);
        check("br_IF_flush", IF_flush, 1);
        check("br_pc_write", pc_write, 1);
        advance();
        clear_inputs();
        settle();
`ifdef PIPE_CTRL_DEBUG_EN
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 2);
`endif

        // x0 producer never stalls
        advance();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        settle();
        check("x0_pc_write", pc_write, 1);
        check("x0_bubble", ID_EX_bubble, 0);

        // imem not ready for 3 cycles, taken branch in the second
        advance();
        clear_inputs();
        imem_ready = 0;
        settle();
        check("imem1_pc_write", pc_write, 0);
        check("imem1_IF_flush", IF_flush, 1);
        advance();
        id_is_branch = 1; branch_taken = 1;
        settle();
        check("imem2_pc_src", pc_src, 1);
        check("imem2_pc_write", pc_write, 1);
        advance();
        id_is_branch = 0; branch_taken = 0;
        settle();
        check("imem3_pc_write", pc_write, 0);
        check("imem3_IF_flush", IF_flush, 1);
        advance();
        imem_ready = 1;
        settle();
`ifdef PIPE_CTRL_DEBUG_EN
        check("imem_stall_cnt", stall_cnt, 4);
        check("imem_flush_cnt", flush_cnt, 4);

        // Halt, single step, resume
        advance();
        dbg_halt_req = 1;
        settle();
        check("halt_accept_halted", halted, 0);
        advance();
        settle();
        check("halt_halted", halted, 1);
        check("halt_pc_write", pc_write, 0);
        advance();
        dbg_step = 1;
        settle();
        check("step_req_halted", halted, 1);
        advance();
        dbg_step = 0;
        settle();
        check("step_halted", halted, 0);
        check("step_pc_write", pc_write, 1);
        advance();
        settle();
        check("step_back_halted", halted, 1);
        check("step_back_pc_write", pc_write, 0);
        advance();
        dbg_halt_req = 0;
        settle();
        check("resume_req_halted", halted, 1);
        advance();
        settle();
        check("resume_halted", halted, 0);
        check("resume_pc_write", pc_write, 1);
`endif

        // Randomized traffic with one asynchronous mid-run reset
        for (int i = 0; i < 3000; i++) begin
            advance();
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                advance();
                advance();
                reset_n = 1'b1;
            end
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            id_is_branch = ($urandom_range(0, 2) == 0);
            branch_taken = 1'($urandom_range(0, 1));
            ex_reg_write = 1'($urandom_range(0, 1));
            ex_mem_read  = ($urandom_range(0, 3) == 0);
            mem_mem_read = ($urandom_range(0, 3) == 0);
            imem_ready   = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) dbg_halt_req = !dbg_halt_req;
            dbg_step     = ($urandom_range(0, 3) == 0);
            settle();
        end

`ifdef PIPE_CTRL_DEBUG_EN
        // Counter saturation under a long fetch stall
        advance();
        clear_inputs();
        reset_n = 1'b0;
        advance();
        reset_n = 1'b1;
        imem_ready = 0;
        repeat (65540) advance();
        settle();
        check("sat_stall_cnt", stall_cnt, 32'hFFFF);
        check("sat_flush_cnt", flush_cnt, 32'hFFFF);
        advance();
        settle();
        check("sat_stall_hold", stall_cnt, 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
